clk_tick_sched: RTL and testbench

Programmable tick scheduler driven by the free-running testbench/system clock. It divides `clk` into one-cycle `tick` enable pulses at a configured period, optionally for a fixed number of ticks, then signals completion. Downstream blocks sequence their work off `tick` instead of owning separate clocks. Configuration uses a valid/ready handshake, and run control uses start/stop pulses.

---
 rtl/clk_tick_sched.sv | 135 +++++++++++++
 tb/tb_clk_tick_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_sched.sv
// Programmable tick scheduler: divides clk into one-cycle tick enables at a
// configured period, optionally for a fixed number of ticks, then pulses done.
module clk_tick_sched #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_r;
  logic [CNT_W-1:0] cnt_r;
  logic [DIV_W-1:0] phase;
  logic [CNT_W-1:0] ticks;

  logic phase_wrap_c;
  logic last_tick_c;
  logic cfg_take_c;

  logic tick_nxt;
  logic done_nxt;
  logic busy_nxt;
  logic ready_nxt;

  assign phase_wrap_c = (phase == DIV_W'(div_r - DIV_W'(1)));
  assign last_tick_c  = (cnt_r != '0) && (ticks == CNT_W'(cnt_r - CNT_W'(1)));
  // cfg_ready is only ever high in IDLE, so it qualifies the handshake alone
  assign cfg_take_c   = cfg_valid && cfg_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop takes priority over a tick due on the same edge
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (phase_wrap_c && last_tick_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output next values, registered below
  always_comb begin
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    ready_nxt = 1'b0;
    if (state == RUN && !stop && phase_wrap_c) begin
      tick_nxt = 1'b1;
      done_nxt = last_tick_c;
    end
    busy_nxt  = (state_nxt == RUN);
    ready_nxt = (state_nxt == IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      tick      <= tick_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      cfg_ready <= ready_nxt;
    end
  end

  // Configuration registers; a zero divisor is stored as 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= DIV_W'(1);
      cnt_r <= '0;
    end else if (cfg_take_c) begin
      div_r <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      cnt_r <= cfg_count;
    end
  end

  // Phase and tick counters; held at zero in IDLE so every run starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      ticks <= '0;
    end else if (state == IDLE) begin
      phase <= '0;
      ticks <= '0;
    end else begin
      if (phase_wrap_c) begin
        phase <= '0;
        if (ticks != '1) begin
          ticks <= CNT_W'(ticks + CNT_W'(1));
        end
      end else begin
        phase <= DIV_W'(phase + DIV_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_sched.sv
// Directed bench for clk_tick_sched: checks {tick,done,busy,cfg_ready} after
// every clock edge against hand-derived schedules.
module tb_clk_tick_sched;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             tick;
  logic             busy;
  logic             done;

  int vectors = 0;
  int miscompares = 0;

  clk_tick_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_count(cfg_count),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {tick, done, busy, cfg_ready};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: {tick,done,busy,ready} observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [DIV_W-1:0] d, input logic [CNT_W-1:0] c);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_count = c;
    step();
    cfg_valid = 1'b0;
    chk("cfg_load", 4'b0001);
  endtask

  initial begin
    // Reset: all outputs low, cfg_ready low while held
    #1 rst_n = 1'b0;
    #2 chk("reset_async", 4'b0000);
    step();
    step();
    chk("reset_held", 4'b0000);
    rst_n = 1'b1;
    step();
    chk("reset_release", 4'b0001);

    // div 4, count 3: ticks at E0+4/8/12, done at E0+12
    load_cfg(8'd4, 16'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_e0", 4'b0010);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t1_k%0d", k), {k % 4 == 0, k == 12, k < 12, k >= 12});
    end
    step();
    chk("t1_idle", 4'b0001);

    // div 0 treated as 1, count 5; config captured on the start edge
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    cfg_count = 16'd5;
    start     = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
    chk("t2_e0", 4'b0010);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t2_k%0d", k), {1'b1, k == 5, k < 5, k == 5});
    end

    // div 3 free-run, stop at E0+9 suppresses that tick
    load_cfg(8'd3, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_e0", 4'b0010);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t3_k%0d", k), {k % 3 == 0, 1'b0, 1'b1, 1'b0});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_stop", 4'b0001);
    for (int k = 10; k <= 30; k++) begin
      step();
      chk($sformatf("t3_after_k%0d", k), 4'b0001);
    end

    // Mid-run config offer stalls; accepted once back in IDLE
    load_cfg(8'd2, 16'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_e0", 4'b0010);
    step();
    chk("t4_k1", 4'b0010);
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    cfg_count = 16'd1;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk($sformatf("t4_k%0d", k), {k % 2 == 0, k == 8, k < 8, k == 8});
    end
    step();
    cfg_valid = 1'b0;
    chk("t4_accept", 4'b0001);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4b_e0", 4'b0010);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("t4b_k%0d", k), {k == 7, k == 7, k < 7, k == 7});
    end

    // Reset mid-run clears config back to div 1 free-run
    load_cfg(8'd4, 16'd10);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t5_k%0d", k), {k == 4, 1'b0, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_async", 4'b0000);
    step();
    chk("t5_rst_held", 4'b0000);
    rst_n = 1'b1;
    step();
    chk("t5_release", 4'b0001);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_e0", 4'b0010);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t5_free_k%0d", k), 4'b1010);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_stop", 4'b0001);

    // stop alone in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t6_stop_idle", 4'b0001);

    // start and stop together in IDLE: start wins
    load_cfg(8'd2, 16'd2);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("t6_e0", 4'b0010);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_k%0d", k), {k % 2 == 0, k == 4, k < 4, k == 4});
    end

    // start held: ignored in RUN, restarts the cycle after done
    start = 1'b1;
    step();
    chk("t7_e0", 4'b0010);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t7_k%0d", k), {k % 2 == 0, k == 4, k < 4, k == 4});
    end
    step();
    start = 1'b0;
    chk("t7_restart", 4'b0010);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t7b_k%0d", k), {k % 2 == 0, k == 4, k < 4, k == 4});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
